// File: rtl/conv_endec_interface.sv
// conv_endec_interface
//   Frame-based hard-decision convolutional codec. One capture edge latches a
//   128-bit information frame and a received code frame; the encoder and a
//   256-state Viterbi decoder then run side by side and publish whole frames.
//
// Ports
//   sys_clk               clock, all logic on the rising edge
//   rst                   asynchronous reset, active low
//   en                    start qualifier (sampled in IDLE), hold high to keep DONE
//   i_code_rate           0 = rate 1/2 (polys 0,1), 1 = rate 1/3 (polys 0,1,2)
//   i_gen_poly_flat       poly i in bits [9i+8:9i], bit j taps the input delayed j steps
//   i_encoder_data_frame  information bits, bit 127 encoded first
//   i_decoder_data_frame  n*128 received bits in [n*128-1:0], first symbol at the top
//   o_encoder_data        coded frame, same packing as the decoder input, unused bits 0
//   o_encoder_done        high while o_encoder_data holds a finished frame
//   o_decoder_data        decoded bits, bit 127 = first trellis step
//   o_decoder_done        high while o_decoder_data holds a finished frame
module conv_endec_interface #(
  parameter int MAX_CONSTRAINT_LENGTH = 9,
  parameter int MAX_CODE_RATE         = 3,
  parameter int FRAME_BITS            = 128
) (
  input  logic                                       sys_clk,
  input  logic                                       rst,
  input  logic                                       en,
  input  logic                                       i_code_rate,
  input  logic [MAX_CODE_RATE*MAX_CONSTRAINT_LENGTH-1:0] i_gen_poly_flat,
  input  logic [FRAME_BITS-1:0]                      i_encoder_data_frame,
  input  logic [MAX_CODE_RATE*FRAME_BITS-1:0]        i_decoder_data_frame,
  output logic [MAX_CODE_RATE*FRAME_BITS-1:0]        o_encoder_data,
  output logic                                       o_encoder_done,
  output logic [FRAME_BITS-1:0]                      o_decoder_data,
  output logic                                       o_decoder_done
);

  localparam int K_W      = MAX_CONSTRAINT_LENGTH;
  localparam int S_W      = K_W - 1;
  localparam int N_STATES = 1 << S_W;
  localparam int CODE_W   = MAX_CODE_RATE * FRAME_BITS;
  localparam int POLY_W   = MAX_CODE_RATE * K_W;
  localparam int PM_W     = 10;
  localparam int CNT_W    = 9;
  localparam int STEP_W   = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_STEP   = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] SELECT_STEP = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_TB     = CNT_W'(2 * FRAME_BITS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt;
  logic                   rate3;
  logic [POLY_W-1:0]      polys;
  logic [FRAME_BITS-1:0]  enc_sr;
  logic [S_W-1:0]         enc_s;
  logic [K_W-1:0]         enc_r;
  logic [2:0]             enc_sym;
  logic [CODE_W-1:0]      enc_acc, enc_acc_next;
  logic [CODE_W-1:0]      dec_sr;
  logic [2:0]             rx;
  logic [PM_W-1:0]        pm      [N_STATES];
  logic [PM_W-1:0]        pm_next [N_STATES];
  logic [N_STATES-1:0]    dec_bits;
  logic [N_STATES-1:0]    surv    [FRAME_BITS];
  logic [S_W-1:0]         best_state, tb_state;
  logic [FRAME_BITS-1:0]  tb_acc;
  logic [CNT_W-1:0]       tb_idx;
  logic                   tb_dec;

  function automatic logic parity_tap(input logic [K_W-1:0] r, input logic [K_W-1:0] poly);
    return ^(r & poly);
  endfunction

  // Hamming distance between the received symbol group and the symbols the
  // encoder would emit for register contents r; slot 2 only counts at rate 1/3.
  function automatic logic [1:0] branch_metric(input logic [K_W-1:0] r, input logic [2:0] rxs,
                                               input logic r3, input logic [POLY_W-1:0] p);
    return 2'(rxs[2] ^ parity_tap(r, p[K_W-1:0]))
         + 2'(rxs[1] ^ parity_tap(r, p[2*K_W-1:K_W]))
         + 2'(r3 & (rxs[0] ^ parity_tap(r, p[3*K_W-1:2*K_W])));
  endfunction

  // Encoder step: register is {state, current input}, symbols packed MSB-first.
  always_comb begin
    enc_r   = {enc_s, enc_sr[FRAME_BITS-1]};
    enc_sym = {parity_tap(enc_r, polys[K_W-1:0]),
               parity_tap(enc_r, polys[2*K_W-1:K_W]),
               parity_tap(enc_r, polys[3*K_W-1:2*K_W])};
    enc_acc_next = rate3 ? {enc_acc[CODE_W-4:0], enc_sym}
                         : {enc_acc[CODE_W-3:0], enc_sym[2:1]};
  end

  assign rx = dec_sr[CODE_W-1 -: 3];

  // ACS: state s is entered from {d, s[7:1]}; the register seen on that branch
  // is {d, s}. Ties keep d=0.
  always_comb begin : acs
    logic [S_W-1:0]  sv;
    logic [PM_W-1:0] m0, m1;
    sv       = '0;
    m0       = '0;
    m1       = '0;
    dec_bits = '0;
    pm_next  = '{default: '0};
    for (int s = 0; s < N_STATES; s++) begin
      sv = S_W'(s);
      m0 = pm[{1'b0, sv[S_W-1:1]}] + PM_W'(branch_metric({1'b0, sv}, rx, rate3, polys));
      m1 = pm[{1'b1, sv[S_W-1:1]}] + PM_W'(branch_metric({1'b1, sv}, rx, rate3, polys));
      dec_bits[s] = (m1 < m0);
      pm_next[s]  = (m1 < m0) ? m1 : m0;
    end
  end

  // Minimum metric; strict compare keeps the lowest index on ties.
  always_comb begin : best_select
    logic [PM_W-1:0] best_m;
    best_state = '0;
    best_m     = pm[0];
    for (int s = 1; s < N_STATES; s++) begin
      if (pm[s] < best_m) begin
        best_m     = pm[s];
        best_state = S_W'(s);
      end
    end
  end

  // Traceback walks steps 127..0 while cnt runs 129..256.
  assign tb_idx = LAST_TB - cnt;
  assign tb_dec = surv[tb_idx[STEP_W-1:0]][tb_state];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (cnt == LAST_TB) state_next = DONE;
      DONE:    if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      cnt            <= '0;
      o_encoder_data <= '0;
      o_encoder_done <= 1'b0;
      o_decoder_data <= '0;
      o_decoder_done <= 1'b0;
    end else begin
      if (state == RUN) cnt <= cnt + CNT_W'(1);
      else              cnt <= '0;
      if (state == RUN && cnt == LAST_STEP) begin
        o_encoder_data <= enc_acc_next;
        o_encoder_done <= 1'b1;
      end
      if (state == RUN && cnt == LAST_TB) begin
        o_decoder_data <= {tb_state[0], tb_acc[FRAME_BITS-1:1]};
        o_decoder_done <= 1'b1;
      end
      if (state == DONE && !en) begin
        o_encoder_done <= 1'b0;
        o_decoder_done <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (state == IDLE && en) begin
      // capture: left-align the received stream so the next symbol is always at the top
      rate3   <= i_code_rate;
      polys   <= i_gen_poly_flat;
      enc_sr  <= i_encoder_data_frame;
      enc_s   <= '0;
      enc_acc <= '0;
      dec_sr  <= i_code_rate ? i_decoder_data_frame
                             : {i_decoder_data_frame[2*FRAME_BITS-1:0], FRAME_BITS'(0)};
      for (int s = 0; s < N_STATES; s++) pm[s] <= (s == 0) ? PM_W'(0) : PM_W'(512);
    end else if (state == RUN) begin
      if (cnt <= LAST_STEP) begin
        // encode + ACS step
        enc_s   <= {enc_s[S_W-2:0], enc_sr[FRAME_BITS-1]};
        enc_sr  <= {enc_sr[FRAME_BITS-2:0], 1'b0};
        enc_acc <= enc_acc_next;
        dec_sr  <= rate3 ? {dec_sr[CODE_W-4:0], 3'b000} : {dec_sr[CODE_W-3:0], 2'b00};
        pm      <= pm_next;
        surv[cnt[STEP_W-1:0]] <= dec_bits;
      end else if (cnt == SELECT_STEP) begin
        // best-state select
        tb_state <= best_state;
      end else begin
        // traceback step
        tb_state <= {tb_dec, tb_state[S_W-1:1]};
        tb_acc   <= {tb_state[0], tb_acc[FRAME_BITS-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_conv_endec_interface.sv
module tb_conv_endec_interface;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         code_rate;
  logic [26:0]  gen_poly;
  logic [127:0] enc_frame;
  logic [383:0] dec_frame;
  logic [383:0] enc_data;
  logic         enc_done;
  logic [127:0] dec_data;
  logic         dec_done;

  int checks = 0;
  int errors = 0;

  localparam logic [26:0] P75 = {9'd0, 9'b000000101, 9'b000000111};
  localparam logic [26:0] PK9 = {9'b100100111, 9'b110011011, 9'b111101101};

  always #5 clk = ~clk;

  conv_endec_interface u_dut (
    .sys_clk              (clk),
    .rst                  (rst),
    .en                   (en),
    .i_code_rate          (code_rate),
    .i_gen_poly_flat      (gen_poly),
    .i_encoder_data_frame (enc_frame),
    .i_decoder_data_frame (dec_frame),
    .o_encoder_data       (enc_data),
    .o_encoder_done       (enc_done),
    .o_decoder_data       (dec_data),
    .o_decoder_done       (dec_done)
  );

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [383:0] rand384();
    return {rand128(), rand128(), rand128()};
  endfunction

  // Reference encoder: direct placement of every symbol at its packed position.
  function automatic logic [383:0] ref_encode(input logic rate3, input logic [26:0] polys,
                                              input logic [127:0] frame);
    logic [383:0] cw;
    logic [7:0]   s;
    logic [8:0]   r;
    int           n;
    cw = '0;
    s  = '0;
    n  = rate3 ? 3 : 2;
    for (int t = 0; t < 128; t++) begin
      r = {s, frame[127-t]};
      for (int i = 0; i < n; i++) cw[n*128-1-n*t-i] = ^(r & polys[9*i +: 9]);
      s = {s[6:0], frame[127-t]};
    end
    return cw;
  endfunction

  // Reference Viterbi decoder using integer metrics and state arithmetic.
  function automatic logic [127:0] ref_decode(input logic rate3, input logic [26:0] polys,
                                              input logic [383:0] rx);
    int         n, best, s, bm;
    int         pm  [256];
    int         npm [256];
    int         c   [2];
    bit         dec [128][256];
    logic [8:0] r;
    logic [127:0] out;
    n = rate3 ? 3 : 2;
    for (int i = 0; i < 256; i++) pm[i] = (i == 0) ? 0 : 512;
    for (int t = 0; t < 128; t++) begin
      for (int st = 0; st < 256; st++) begin
        for (int d = 0; d < 2; d++) begin
          r  = 9'(d * 256 + st);
          bm = 0;
          for (int i = 0; i < n; i++)
            if (rx[n*128-1-n*t-i] != ^(r & polys[9*i +: 9])) bm++;
          c[d] = pm[d*128 + st/2] + bm;
        end
        dec[t][st] = (c[1] < c[0]);
        npm[st]    = (c[1] < c[0]) ? c[1] : c[0];
      end
      pm = npm;
    end
    best = 0;
    for (int i = 1; i < 256; i++) if (pm[i] < pm[best]) best = i;
    s   = best;
    out = '0;
    for (int t = 127; t >= 0; t--) begin
      out[127-t] = 1'(s % 2);
      s = int'(dec[t][s]) * 128 + s / 2;
    end
    return out;
  endfunction

  task automatic run_frame(input logic rate, input logic [26:0] polys, input logic [127:0] ef,
                           input logic [383:0] df, input bit scramble,
                           output logic [383:0] enc_o, output logic [127:0] dec_o,
                           output int timing_bad);
    @(negedge clk);
    code_rate = rate;
    gen_poly  = polys;
    enc_frame = ef;
    dec_frame = df;
    en        = 1'b1;
    @(posedge clk);
    timing_bad = 0;
    for (int k = 1; k <= 257; k++) begin
      @(negedge clk);
      if (scramble && k < 256) begin
        en        = 1'($urandom);
        code_rate = 1'($urandom);
        gen_poly  = 27'($urandom);
        enc_frame = rand128();
        dec_frame = rand384();
      end else begin
        en = 1'b1;
      end
      @(posedge clk);
      #1;
      if (enc_done !== (k >= 128) || dec_done !== (k >= 257)) timing_bad++;
    end
    enc_o = enc_data;
    dec_o = dec_data;
  endtask

  task automatic end_frame();
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (enc_data !== '0 || dec_data !== '0 || enc_done !== 1'b0 || dec_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs enc=%h dec=%h flags=%b%b required all zero",
               enc_data, dec_data, enc_done, dec_done);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (enc_done !== 1'b0 || dec_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_flags flags=%b%b required 00", enc_done, dec_done);
    end
  endtask

  task automatic test_impulse();
    logic [383:0] exp_enc, got_e;
    logic [127:0] exp_dec, got_d;
    int           tbad;
    exp_enc = '0;
    exp_enc[255:250] = 6'b111011;
    exp_dec = '0;
    exp_dec[127] = 1'b1;
    run_frame(1'b0, P75, exp_dec, exp_enc, 1'b0, got_e, got_d, tbad);
    checks++;
    if (got_e !== exp_enc) begin
      errors++;
      $display("FAIL impulse_enc got=%h required=%h", got_e, exp_enc);
    end
    checks++;
    if (got_d !== exp_dec) begin
      errors++;
      $display("FAIL impulse_dec got=%h required=%h", got_d, exp_dec);
    end
    checks++;
    if (tbad !== 0) begin
      errors++;
      $display("FAIL impulse_timing bad_cycles=%0d required=0", tbad);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (enc_done !== 1'b1 || dec_done !== 1'b1) begin
      errors++;
      $display("FAIL done_hold flags=%b%b required 11", enc_done, dec_done);
    end
    end_frame();
    checks++;
    if (enc_done !== 1'b0 || dec_done !== 1'b0 || enc_data !== exp_enc || dec_data !== exp_dec) begin
      errors++;
      $display("FAIL done_release flags=%b%b enc=%h dec=%h required flags 00, data kept",
               enc_done, dec_done, enc_data, dec_data);
    end
  endtask

  task automatic test_all_zero();
    logic [383:0] got_e;
    logic [127:0] got_d;
    int           tbad;
    for (int r = 0; r < 2; r++) begin
      run_frame(1'(r), (r == 1) ? PK9 : P75, '0, '0, 1'b0, got_e, got_d, tbad);
      checks++;
      if (got_e !== '0 || got_d !== '0 || tbad !== 0) begin
        errors++;
        $display("FAIL zero_rate%0d enc=%h dec=%h timing_bad=%0d required zero", r, got_e, got_d, tbad);
      end
      end_frame();
    end
  endtask

  task automatic test_round_trip(input logic rate, input logic [26:0] polys);
    logic [127:0] ef, ef2, got_d;
    logic [383:0] got_e, cw;
    int           tbad;
    ef = rand128();
    run_frame(rate, polys, ef, rand384(), 1'b0, got_e, got_d, tbad);
    cw = ref_encode(rate, polys, ef);
    checks++;
    if (got_e !== cw) begin
      errors++;
      $display("FAIL rt_enc_rate%0d got=%h required=%h", rate, got_e, cw);
    end
    end_frame();
    ef2 = rand128();
    run_frame(rate, polys, ef2, got_e, 1'b1, got_e, got_d, tbad);
    checks++;
    if (got_d !== ef) begin
      errors++;
      $display("FAIL rt_dec_rate%0d got=%h required=%h", rate, got_d, ef);
    end
    checks++;
    if (got_e !== ref_encode(rate, polys, ef2) || tbad !== 0) begin
      errors++;
      $display("FAIL rt_scrambled_rate%0d enc=%h timing_bad=%0d required enc=%h timing_bad=0",
               rate, got_e, tbad, ref_encode(rate, polys, ef2));
    end
    end_frame();
  endtask

  task automatic test_error_correction();
    logic [127:0] ef, got_d;
    logic [383:0] cw, rx, got_e;
    int           tbad;
    ef = rand128();
    cw = ref_encode(1'b0, P75, ef);
    rx = cw;
    rx[255 - 2*64] = ~rx[255 - 2*64];
    run_frame(1'b0, P75, ef, rx, 1'b0, got_e, got_d, tbad);
    checks++;
    if (got_d !== ef) begin
      errors++;
      $display("FAIL ecc_one_flip got=%h required=%h", got_d, ef);
    end
    end_frame();
    rx = cw;
    rx[255 - 2*40]     = ~rx[255 - 2*40];
    rx[255 - 2*90 - 1] = ~rx[255 - 2*90 - 1];
    run_frame(1'b0, P75, ef, rx, 1'b0, got_e, got_d, tbad);
    checks++;
    if (got_d !== ef) begin
      errors++;
      $display("FAIL ecc_two_flips got=%h required=%h", got_d, ef);
    end
    end_frame();
  endtask

  task automatic test_random_stream();
    logic         rate;
    logic [26:0]  polys;
    logic [127:0] ef, got_d, exp_d;
    logic [383:0] df, got_e, exp_e;
    int           tbad;
    for (int it = 0; it < 3; it++) begin
      rate  = 1'(it % 2);
      polys = 27'($urandom) | 27'h0040201;
      ef    = rand128();
      df    = rand384();
      exp_e = ref_encode(rate, polys, ef);
      exp_d = ref_decode(rate, polys, df);
      run_frame(rate, polys, ef, df, 1'b0, got_e, got_d, tbad);
      checks++;
      if (got_e !== exp_e) begin
        errors++;
        $display("FAIL rand_enc_%0d got=%h required=%h", it, got_e, exp_e);
      end
      checks++;
      if (got_d !== exp_d) begin
        errors++;
        $display("FAIL rand_dec_%0d got=%h required=%h", it, got_d, exp_d);
      end
      end_frame();
    end
  endtask

  task automatic test_reset_midrun();
    logic [127:0] ef, got_d;
    logic [383:0] cw, got_e;
    int           tbad;
    ef = rand128();
    cw = ref_encode(1'b0, P75, ef);
    @(negedge clk);
    code_rate = 1'b0;
    gen_poly  = P75;
    enc_frame = ef;
    dec_frame = cw;
    en        = 1'b1;
    @(posedge clk);
    repeat (60) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (enc_data !== '0 || dec_data !== '0 || enc_done !== 1'b0 || dec_done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset enc=%h dec=%h flags=%b%b required all zero",
               enc_data, dec_data, enc_done, dec_done);
    end
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_frame(1'b0, P75, ef, cw, 1'b0, got_e, got_d, tbad);
    checks++;
    if (got_e !== cw || got_d !== ef || tbad !== 0) begin
      errors++;
      $display("FAIL restart enc=%h dec=%h timing_bad=%0d required dec=%h", got_e, got_d, tbad, ef);
    end
    end_frame();
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    code_rate = 1'b0;
    gen_poly  = '0;
    enc_frame = '0;
    dec_frame = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_impulse();
    test_all_zero();
    test_round_trip(1'b0, P75);
    test_round_trip(1'b1, PK9);
    test_error_correction();
    test_random_stream();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
